ped_crossing_ctrl: RTL

//  Pedestrian signal stage downstream of the vehicle traffic-light FSM.

---
 rtl/ped_crossing_ctrl_if.sv | 43 ++++
 rtl/ped_crossing_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl_if.sv
// Pedestrian crossing signal bundle.
//  slave  : the controller side (consumes lights/button, drives lamps/flags).
//  master : the environment side (drives lights/button, observes lamps/flags).
//  Signals:
//   light_red/light_yellow/light_green : vehicle light state
//   ped_button                         : raw asynchronous pedestrian button
//   walk/dont_walk                     : pedestrian lamps
//   request_pending                    : latched request awaiting service
//   fault                              : sticky illegal-light flag
//   chirp                              : audible pulse (only with PED_AUDIBLE_EN defined)
interface ped_crossing_ctrl_if;
  logic light_red;
  logic light_yellow;
  logic light_green;
  logic ped_button;
  logic walk;
  logic dont_walk;
  logic request_pending;
  logic fault;
`ifdef PED_AUDIBLE_EN
  logic chirp;

  modport slave (
    input  light_red, light_yellow, light_green, ped_button,
    output walk, dont_walk, request_pending, fault, chirp
  );

  modport master (
    output light_red, light_yellow, light_green, ped_button,
    input  walk, dont_walk, request_pending, fault, chirp
  );
`else
  modport slave (
    input  light_red, light_yellow, light_green, ped_button,
    output walk, dont_walk, request_pending, fault
  );

  modport master (
    output light_red, light_yellow, light_green, ped_button,
    input  walk, dont_walk, request_pending, fault
  );
`endif
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal stage downstream of the vehicle traffic-light FSM.
// Latches button requests and grants a steady WALK interval followed by a flashing
// clearance interval at the start of the next red phase. Any illegal light combination
// forces a sticky fault mode that only reset can leave.
// Ports:
//  clk   : clock, rising edge
//  reset : asynchronous, active-high
//  bus   : ped_crossing_ctrl_if.slave (lights, button in; walk, dont_walk,
//          request_pending, fault out; chirp out when PED_AUDIBLE_EN is defined)
// Build option: define PED_AUDIBLE_EN to add the audible chirp output.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_CYCLES  = 6,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned FLASH_HALF   = 1,
  parameter int unsigned CNT_W        = 4
) (
  input logic                 clk,
  input logic                 reset,
  ped_crossing_ctrl_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWalk  = 2'd1;
  localparam logic [1:0] StClear = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  localparam logic [CNT_W-1:0] WalkLoad  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ClearLoad = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] FlashLast = CNT_W'(FLASH_HALF - 1);

  // Button synchronizer and edge detector.
  logic btn_sync1_q, btn_sync2_q, btn_prev_q;
  logic btn_evt;

  // Registered lights {red, yellow, green} and previous red.
  logic [2:0] light_q;
  logic       red_prev_q;
  logic       red_rise;
  logic       lights_ok;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             flash_q, flash_d;
  logic             req_q, req_d;
  logic             flash_tick;

  logic walk, dont_walk, fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      btn_prev_q  <= 1'b0;
    end else begin
      btn_sync1_q <= bus.ped_button;
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_sync2_q;
    end
  end

  assign btn_evt = btn_sync2_q & ~btn_prev_q;

  // light_q resets to a legal "red" with red_prev set, so the first sampled cycle after
  // reset neither looks illegal nor fabricates a red rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light_q    <= 3'b100;
      red_prev_q <= 1'b1;
    end else begin
      light_q    <= {bus.light_red, bus.light_yellow, bus.light_green};
      red_prev_q <= light_q[2];
    end
  end

  assign red_rise   = light_q[2] & ~red_prev_q;
  assign lights_ok  = (light_q == 3'b100) || (light_q == 3'b010) || (light_q == 3'b001);
  assign flash_tick = (fcnt_q >= FlashLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    fcnt_d  = fcnt_q;
    flash_d = flash_q;

    unique case (state_q)
      StIdle: begin
        if (red_rise && req_q) begin
          state_d = StWalk;
          cnt_d   = WalkLoad;
        end
      end
      StWalk: begin
        if (!light_q[2]) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StClear;
          cnt_d   = ClearLoad;
          flash_d = 1'b1;
          fcnt_d  = '0;
        end
      end
      StClear: begin
        if (flash_tick) begin
          flash_d = ~flash_q;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_q + CNT_W'(1);
        end
        if (!light_q[2] || (cnt_q == '0)) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        if (flash_tick) begin
          flash_d = ~flash_q;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Illegal lights override every other transition; flash restarts on entry only.
    if (!lights_ok && (state_q != StFault)) begin
      state_d = StFault;
      flash_d = 1'b1;
      fcnt_d  = '0;
    end
  end

  // Request latch: cleared on WALK entry even if a new press lands in that same cycle.
  always_comb begin
    req_d = req_q;
    if ((state_q == StFault) || (state_d == StFault)) begin
      req_d = 1'b0;
    end else if ((state_q != StWalk) && (state_d == StWalk)) begin
      req_d = 1'b0;
    end else if (btn_evt) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      flash_q <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    fault     = 1'b0;
    unique case (state_q)
      StIdle:  dont_walk = 1'b1;
      StWalk: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      StClear: dont_walk = flash_q;
      StFault: begin
        dont_walk = flash_q;
        fault     = 1'b1;
      end
      default: dont_walk = 1'b1;
    endcase
  end

  assign bus.walk            = walk;
  assign bus.dont_walk       = dont_walk;
  assign bus.request_pending = req_q;
  assign bus.fault           = fault;

`ifdef PED_AUDIBLE_EN
  // Free 2-bit counter: zero on the first WALK cycle, wraps every 4 WALK cycles.
  logic [1:0] chirp_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chirp_cnt_q <= 2'd0;
    end else if ((state_q != StWalk) && (state_d == StWalk)) begin
      chirp_cnt_q <= 2'd0;
    end else if (state_q == StWalk) begin
      chirp_cnt_q <= chirp_cnt_q + 2'd1;
    end
  end

  assign bus.chirp = (state_q == StWalk) && (chirp_cnt_q == 2'd0);
`endif

endmodule
